// File: rtl/mult_arb_pkg.sv
// Shared types and widths for the sign-magnitude multiplier arbiter.
package mult_arb_pkg;

  // Requester operand: 1 sign bit + 8-bit magnitude.
  localparam int OP_W     = 9;
  localparam int MAG_W    = 8;
  // Returned product: 1 sign bit + 16-bit magnitude.
  localparam int PRD_W    = 17;
  // Position of the sign bit inside an operand.
  localparam int SIGN_BIT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/mult_arb_rr_pick.sv
// Combinational round-robin picker: the first set request bit strictly
// after 'last', wrapping around to bit 0.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // Search the upper segment (above last) first, then the lower one.
  always_comb begin
    int  hi_sel;
    int  lo_sel;
    int  sel;
    logic hi_found;
    // NOTE: every variable gets a default before any branch so that no path
    // leaves it unassigned; an unassigned path would infer a latch.
    hi_sel   = 0;
    lo_sel   = 0;
    sel      = 0;
    hi_found = 1'b0;
    pick     = '0;
    idx      = '0;
    valid    = |req;
    // Walking downward means the lowest qualifying bit is written last.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && (i > int'(last))) begin
        hi_sel   = i;
        hi_found = 1'b1;
      end
      if (req[i] && (i <= int'(last))) begin
        lo_sel = i;
      end
    end
    sel = hi_found ? hi_sel : lo_sel;
    if (valid) begin
      pick[sel] = 1'b1;
      idx       = IW'(sel);
    end
  end

endmodule

// File: rtl/mult_arbiter_8.sv
// Round-robin sequencer sharing one multi-cycle 8x8 unsigned multiplier
// core among N_REQ sign-magnitude requesters, with a no-answer watchdog.
module mult_arbiter_8
  import mult_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [OP_W*N_REQ-1:0]  op_a,
  input  logic [OP_W*N_REQ-1:0]  op_b,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic [PRD_W-1:0]       prdct,
  output logic                   err,
  output logic                   busy,
  output logic                   mul_en,
  output logic [MAG_W-1:0]       mul_a,
  output logic [MAG_W-1:0]       mul_b,
  input  logic [2*MAG_W-1:0]     mul_result,
  input  logic                   mul_rdy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t               state_q, state_nx;
  logic [IDX_W-1:0]     idx_q, idx_nx;
  logic [IDX_W-1:0]     last_q, last_nx;
  logic                 sign_q, sign_nx;
  logic [CNT_W-1:0]     cnt_q, cnt_nx;
  logic [N_REQ-1:0]     grant_nx, done_nx;
  logic [PRD_W-1:0]     prdct_nx;
  logic                 err_nx, busy_nx, mul_en_nx;
  logic [MAG_W-1:0]     mul_a_nx, mul_b_nx;

  logic [N_REQ-1:0]     pick_oh;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_vld;
  logic [OP_W-1:0]      sel_a, sel_b;

  rr_pick #(
    .N  (N_REQ),
    .IW (IDX_W)
  ) u_pick (
    .req   (req),
    .last  (last_q),
    .pick  (pick_oh),
    .idx   (pick_idx),
    .valid (pick_vld)
  );

  // Operands of the requester the picker currently favours.
  assign sel_a = op_a[int'(pick_idx)*OP_W +: OP_W];
  assign sel_b = op_b[int'(pick_idx)*OP_W +: OP_W];

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_nx  = state_q;
    idx_nx    = idx_q;
    last_nx   = last_q;
    sign_nx   = sign_q;
    cnt_nx    = cnt_q;
    grant_nx  = grant;
    busy_nx   = busy;
    mul_a_nx  = mul_a;
    mul_b_nx  = mul_b;
    mul_en_nx = 1'b0;
    done_nx   = '0;
    prdct_nx  = '0;
    err_nx    = 1'b0;
    case (state_q)
      IDLE: begin
        // Operands are latched here; later changes on op_a/op_b are ignored.
        if (pick_vld) begin
          idx_nx    = pick_idx;
          sign_nx   = sel_a[SIGN_BIT] ^ sel_b[SIGN_BIT];
          mul_a_nx  = sel_a[MAG_W-1:0];
          mul_b_nx  = sel_b[MAG_W-1:0];
          mul_en_nx = 1'b1;
          grant_nx  = pick_oh;
          busy_nx   = 1'b1;
          state_nx  = ISSUE;
        end
      end
      ISSUE: begin
        // A mul_rdy seen during this cycle is deliberately not looked at.
        cnt_nx   = '0;
        state_nx = WAIT;
      end
      WAIT: begin
        if (mul_rdy) begin
          done_nx  = grant;
          // A zero magnitude is always reported as +0.
          prdct_nx = {sign_q & (|mul_result), mul_result};
          state_nx = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          done_nx  = grant;
          err_nx   = 1'b1;
          state_nx = RESP;
        end else begin
          cnt_nx = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        last_nx  = idx_q;
        grant_nx = '0;
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and output registers; reset discards any transaction in flight.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      last_q  <= IDX_W'(N_REQ - 1);
      sign_q  <= 1'b0;
      cnt_q   <= '0;
      grant   <= '0;
      done    <= '0;
      prdct   <= '0;
      err     <= 1'b0;
      busy    <= 1'b0;
      mul_en  <= 1'b0;
      mul_a   <= '0;
      mul_b   <= '0;
    end else begin
      state_q <= state_nx;
      idx_q   <= idx_nx;
      last_q  <= last_nx;
      sign_q  <= sign_nx;
      cnt_q   <= cnt_nx;
      grant   <= grant_nx;
      done    <= done_nx;
      prdct   <= prdct_nx;
      err     <= err_nx;
      busy    <= busy_nx;
      mul_en  <= mul_en_nx;
      mul_a   <= mul_a_nx;
      mul_b   <= mul_b_nx;
    end
  end

endmodule

// File: tb/tb_mult_arbiter_8.sv
// Scoreboard bench for mult_arbiter_8 with a behavioural multiplier core.
module tb_mult_arbiter_8;

  localparam int N_REQ   = 4;
  localparam int TIMEOUT = 32;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [N_REQ-1:0]     req = '0;
  logic [9*N_REQ-1:0]   op_a = '0;
  logic [9*N_REQ-1:0]   op_b = '0;
  logic [N_REQ-1:0]     grant, done;
  logic [16:0]          prdct;
  logic                 err, busy, mul_en;
  logic [7:0]           mul_a, mul_b;
  logic [15:0]          mul_result = '0;
  logic                 mul_rdy = 1'b0;

  always #5 clk = ~clk;

  mult_arbiter_8 #(
    .N_REQ   (N_REQ),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .op_a       (op_a),
    .op_b       (op_b),
    .grant      (grant),
    .done       (done),
    .prdct      (prdct),
    .err        (err),
    .busy       (busy),
    .mul_en     (mul_en),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_result (mul_result),
    .mul_rdy    (mul_rdy)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int          idx;
    logic [16:0] prd;
    logic        err;
  } exp_t;

  exp_t sb[$];

  int core_lat   = 1;
  bit core_never = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int idx, input logic [16:0] prd, input logic e);
    exp_t x;
    x.idx = idx;
    x.prd = prd;
    x.err = e;
    sb.push_back(x);
  endtask

  task automatic set_ops(input int i, input logic [8:0] a, input logic [8:0] b);
    op_a[i*9 +: 9] = a;
    op_b[i*9 +: 9] = b;
  endtask

  task automatic wait_mul_en(output int c);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!mul_en && c < 100);
    if (!mul_en) begin
      n_vec++;
      n_err++;
      $display("FAIL mul_en_wait: got no mul_en within %0d cycles, expected one", c);
    end
  endtask

  task automatic wait_done(output int c);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (done == '0 && c < 100);
    if (done == '0) begin
      n_vec++;
      n_err++;
      $display("FAIL done_wait: got no done within %0d cycles, expected one", c);
    end
  endtask

  // Behavioural core: latches operands on mul_en, answers core_lat cycles later.
  initial begin
    logic [7:0] ca;
    logic [7:0] cb;
    forever begin
      @(posedge clk);
      #1;
      if (mul_en && !core_never) begin
        ca = mul_a;
        cb = mul_b;
        if (core_lat > 0) begin
          repeat (core_lat) @(posedge clk);
          #1;
        end
        mul_rdy    = 1'b1;
        mul_result = 16'(ca) * 16'(cb);
        @(posedge clk);
        #1;
        mul_rdy    = 1'b0;
        mul_result = 16'hDEAD;
      end
    end
  end

  // Monitor: every done pulse is checked against the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (done !== '0) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_done: got done=%b, expected no done", done);
        end else begin
          exp_t e;
          logic [N_REQ-1:0] oh;
          e = sb.pop_front();
          oh = '0;
          oh[e.idx] = 1'b1;
          check("done_onehot", done, oh);
          check("grant_in_resp", grant, oh);
          check("prdct", prdct, e.prd);
          check("err", err, e.err);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int c;
    int seen;

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_outputs", {grant, done, prdct, err, busy, mul_en}, '0);
    check("rst_mul_ops", {mul_a, mul_b}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single requester: +3 * -5 = -15, core answers 3 cycles after mul_en.
    set_ops(0, 9'h003, 9'h105);
    core_lat = 3;
    push(0, 17'h1000F, 1'b0);
    req = 4'b0001;
    wait_mul_en(c);
    check("mul_en_latency", c, 1);
    check("grant_issue", grant, 4'b0001);
    check("busy_issue", busy, 1'b1);
    wait_done(c);
    check("done_latency", c, 4);
    req = '0;
    @(negedge clk);
    check("idle_after_resp", {busy, grant, mul_en}, '0);

    // -0 * +7 must come back as +0 (requester 3, leaves last = 3).
    set_ops(3, 9'h100, 9'h007);
    core_lat = 2;
    push(3, 17'h00000, 1'b0);
    req = 4'b1000;
    wait_done(c);
    req = '0;
    @(negedge clk);

    // Fairness with all requests held: order 0,1,2,3,0, 4-cycle turnaround.
    set_ops(0, 9'h002, 9'h003);   // +2 * +3  = +6
    set_ops(1, 9'h003, 9'h104);   // +3 * -4  = -12
    set_ops(2, 9'h105, 9'h106);   // -5 * -6  = +30
    set_ops(3, 9'h107, 9'h008);   // -7 * +8  = -56
    core_lat = 1;
    push(0, 17'h00006, 1'b0);
    push(1, 17'h1000C, 1'b0);
    push(2, 17'h0001E, 1'b0);
    push(3, 17'h10038, 1'b0);
    push(0, 17'h00006, 1'b0);
    req = 4'b1111;
    wait_done(c);
    for (int k = 1; k < 5; k++) begin
      wait_done(c);
      check("turnaround", c, 4);
    end
    req = '0;
    @(negedge clk);

    // Silent core: abort TIMEOUT+2 cycles after mul_en with err and +0.
    core_never = 1'b1;
    push(1, 17'h00000, 1'b1);
    req = 4'b0010;
    wait_mul_en(c);
    wait_done(c);
    check("timeout_latency", c, TIMEOUT + 2);
    req = '0;
    core_never = 1'b0;
    @(negedge clk);

    // Next request after a timeout is served normally.
    core_lat = 2;
    push(1, 17'h1000C, 1'b0);
    req = 4'b0010;
    wait_done(c);
    req = '0;
    @(negedge clk);

    // A mul_rdy in the ISSUE cycle is ignored, so this one times out.
    core_lat = 0;
    push(1, 17'h00000, 1'b1);
    req = 4'b0010;
    wait_done(c);
    req = '0;
    @(negedge clk);

    // Asynchronous reset during WAIT clears outputs at once.
    core_lat = 10;
    req = 4'b0001;
    wait_mul_en(c);
    repeat (2) @(negedge clk);
    check("busy_in_wait", busy, 1'b1);
    req = '0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_outputs", {grant, done, prdct, err, busy, mul_en}, '0);
    check("async_rst_mul_ops", {mul_a, mul_b}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // The core's late answer lands in IDLE and must not produce a done.
    seen = 0;
    repeat (14) begin
      @(negedge clk);
      if (done !== '0) seen++;
    end
    check("late_rdy_no_done", seen, 0);

    // Pointer back at N_REQ-1: requester 0 beats requester 3.
    core_lat = 2;
    set_ops(0, 9'h002, 9'h003);
    set_ops(3, 9'h107, 9'h008);
    push(0, 17'h00006, 1'b0);
    push(3, 17'h10038, 1'b0);
    req = 4'b1001;
    wait_done(c);
    req = 4'b1000;
    wait_done(c);
    req = '0;
    @(negedge clk);

    // Request dropped and operands changed mid-flight; 255 * -255.
    core_lat = 5;
    set_ops(2, 9'h0FF, 9'h1FF);
    push(2, 17'h1FE01, 1'b0);
    req = 4'b0100;
    wait_mul_en(c);
    @(negedge clk);
    req = '0;
    set_ops(2, 9'h001, 9'h001);
    wait_done(c);
    check("drop_done_latency", c, 5);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
